// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: FSM states, default widths and the
// table of program entry addresses.
package seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StRun,
        StDone
    } state_e;

    localparam int unsigned PC_W_DEF           = 11;
    localparam int unsigned CNT_W_DEF          = 16;
    localparam int unsigned INIT_CYCLES_DEF    = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 32'h0000_FFF0;
    localparam int unsigned NUM_PROG_DEF       = 4;

    localparam int unsigned NUM_PROG_ADDR = 4;
    localparam logic [31:0] PROG_ADDR [NUM_PROG_ADDR] = '{32'd0, 32'd256, 32'd512, 32'd768};

    // Indices outside the populated table fall back to program 0.
    function automatic logic [31:0] prog_addr(int unsigned sel, int unsigned num_prog);
        if (sel < num_prog && sel < NUM_PROG_ADDR) begin
            return PROG_ADDR[sel];
        end
        return PROG_ADDR[0];
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Saturating run-cycle counter; tc_o flags that the enabled edge will bring the count to
// TIMEOUT_CYCLES.
module seq_watchdog #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 32'h0000_FFF0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = en_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/program_sequencer.sv
// Sequences the CPU core through program runs: start edge detection, program selection,
// init hold, run with watchdog, and completion reporting.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned PC_W           = PC_W_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned INIT_CYCLES    = INIT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned NUM_PROG       = NUM_PROG_DEF,
    localparam int unsigned SelW          = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [SelW-1:0]  prog_sel_i,
    input  logic             core_halt_i,
    output logic             core_init_o,
    output logic [PC_W-1:0]  start_addr_o,
    output logic             busy_o,
    output logic             ack_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic             timeout_o
);

    localparam int unsigned InitW = $clog2(INIT_CYCLES + 1);

    state_e            state_q, state_d;
    logic              start_q;
    logic [InitW-1:0]  init_cnt_q, init_cnt_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic              timeout_q, timeout_d;
    logic              wd_clr, wd_en, wd_tc;
    logic              req;

    assign req = start_i && !start_q;

    seq_watchdog #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (wd_clr),
        .en_i    (wd_en),
        .count_o (cycle_count_o),
        .tc_o    (wd_tc)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        addr_d     = addr_q;
        timeout_d  = timeout_q;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (req) begin
                    addr_d     = PC_W'(prog_addr(int'(unsigned'(prog_sel_i)), NUM_PROG));
                    timeout_d  = 1'b0;
                    init_cnt_d = '0;
                    wd_clr     = 1'b1;
                    state_d    = StInit;
                end
            end
            StInit: begin
                init_cnt_d = init_cnt_q + InitW'(1);
                if (init_cnt_q == InitW'(INIT_CYCLES - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                wd_en = 1'b1;
                // A halt on the terminal edge still counts as a clean finish.
                if (core_halt_i) begin
                    timeout_d = 1'b0;
                    state_d   = StDone;
                end else if (wd_tc) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // start_q resets high so a Start held through reset is not seen as an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            start_q    <= 1'b1;
            init_cnt_q <= '0;
            addr_q     <= PC_W'(PROG_ADDR[0]);
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_i;
            init_cnt_q <= init_cnt_d;
            addr_q     <= addr_d;
            timeout_q  <= timeout_d;
        end
    end

    assign core_init_o  = (state_q != StRun);
    assign busy_o       = (state_q == StInit) || (state_q == StRun);
    assign ack_o        = (state_q == StDone);
    assign start_addr_o = addr_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer, built with a 20-cycle watchdog so the
// timeout path is reachable quickly.
module tb_program_sequencer;

    localparam int unsigned PC_W  = 11;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       prog_sel;
    logic             core_halt;
    logic             core_init;
    logic [PC_W-1:0]  start_addr;
    logic             busy;
    logic             ack;
    logic [CNT_W-1:0] cycle_count;
    logic             timeout;

    int n_checks;
    int n_errors;

    program_sequencer #(
        .PC_W           (PC_W),
        .CNT_W          (CNT_W),
        .INIT_CYCLES    (2),
        .TIMEOUT_CYCLES (20),
        .NUM_PROG       (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .prog_sel_i    (prog_sel),
        .core_halt_i   (core_halt),
        .core_init_o   (core_init),
        .start_addr_o  (start_addr),
        .busy_o        (busy),
        .ack_o         (ack),
        .cycle_count_o (cycle_count),
        .timeout_o     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise Start so the next edge takes it as a request; returns just after that edge.
    task automatic do_start(input logic [1:0] sel);
        prog_sel = sel;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Called in RUN cycle 1; the core halts in RUN cycle n.
    task automatic halt_on_cycle(input int n);
        for (int i = 0; i < n - 1; i++) step();
        core_halt = 1'b1;
        step();
        core_halt = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_core_init"}, 32'(core_init), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_count"}, 32'(cycle_count), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_addr"}, 32'(start_addr), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        start     = 1'b1;
        prog_sel  = 2'd3;
        core_halt = 1'b0;

        // Start held high through reset must not launch a run.
        repeat (3) step();
        check_reset_vals("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("held_start_busy", 32'(busy), 32'd0);
            check("held_start_ack", 32'(ack), 32'd0);
            check("held_start_init", 32'(core_init), 32'd1);
        end
        start = 1'b0;
        step();

        // Program 2, halt on 5th RUN cycle.
        do_start(2'd2);
        check("p2_busy", 32'(busy), 32'd1);
        check("p2_init0", 32'(core_init), 32'd1);
        check("p2_addr", 32'(start_addr), 32'd512);
        step();
        check("p2_init1", 32'(core_init), 32'd1);
        check("p2_addr1", 32'(start_addr), 32'd512);
        step();
        check("p2_run_init", 32'(core_init), 32'd0);
        check("p2_run_busy", 32'(busy), 32'd1);
        halt_on_cycle(5);
        check("p2_ack", 32'(ack), 32'd1);
        check("p2_count", 32'(cycle_count), 32'd5);
        check("p2_timeout", 32'(timeout), 32'd0);
        check("p2_done_busy", 32'(busy), 32'd0);
        check("p2_done_init", 32'(core_init), 32'd1);
        repeat (2) step();
        check("p2_hold_ack", 32'(ack), 32'd1);
        check("p2_hold_count", 32'(cycle_count), 32'd5);

        // Back-to-back: program 1 then program 3.
        do_start(2'd1);
        check("p1_addr", 32'(start_addr), 32'd256);
        check("p1_ack_clr", 32'(ack), 32'd0);
        check("p1_count_clr", 32'(cycle_count), 32'd0);
        repeat (2) step();
        halt_on_cycle(3);
        check("p1_count", 32'(cycle_count), 32'd3);
        check("p1_ack", 32'(ack), 32'd1);
        do_start(2'd3);
        check("p3_addr", 32'(start_addr), 32'd768);
        check("p3_ack_clr", 32'(ack), 32'd0);
        check("p3_count_clr", 32'(cycle_count), 32'd0);
        repeat (2) step();
        halt_on_cycle(2);
        check("p3_count", 32'(cycle_count), 32'd2);
        check("p3_ack", 32'(ack), 32'd1);

        // Halt held through INIT is ignored; ends on first RUN cycle.
        core_halt = 1'b1;
        do_start(2'd0);
        check("stale_busy", 32'(busy), 32'd1);
        check("stale_addr", 32'(start_addr), 32'd0);
        step();
        check("stale_init1", 32'(core_init), 32'd1);
        check("stale_ack1", 32'(ack), 32'd0);
        step();
        check("stale_run", 32'(core_init), 32'd0);
        check("stale_ack2", 32'(ack), 32'd0);
        step();
        core_halt = 1'b0;
        check("stale_ack", 32'(ack), 32'd1);
        check("stale_count", 32'(cycle_count), 32'd1);

        // Watchdog fires after 20 RUN cycles.
        do_start(2'd1);
        repeat (2) step();
        repeat (19) step();
        check("wd_pre_busy", 32'(busy), 32'd1);
        check("wd_pre_count", 32'(cycle_count), 32'd19);
        step();
        check("wd_ack", 32'(ack), 32'd1);
        check("wd_timeout", 32'(timeout), 32'd1);
        check("wd_count", 32'(cycle_count), 32'd20);

        // Halt on cycle 20 beats the watchdog.
        do_start(2'd1);
        check("wd2_timeout_clr", 32'(timeout), 32'd0);
        repeat (2) step();
        halt_on_cycle(20);
        check("wd2_ack", 32'(ack), 32'd1);
        check("wd2_timeout", 32'(timeout), 32'd0);
        check("wd2_count", 32'(cycle_count), 32'd20);

        // Extra Start during RUN is ignored; mid-RUN reset aborts asynchronously.
        do_start(2'd2);
        repeat (2) step();
        repeat (2) step();
        check("ign_count_pre", 32'(cycle_count), 32'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_run", 32'(core_init), 32'd0);
        check("ign_count", 32'(cycle_count), 32'd3);
        step();
        check("ign_count2", 32'(cycle_count), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        core_halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_ack", 32'(ack), 32'd0);
        end
        core_halt = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_ack", 32'(ack), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Sequences the CPU core through program runs: accepts a host Start request, selects one of NUM_PROG program entry addresses, holds the core in init for a fixed number of cycles, releases it, and waits for the core's halt. Reports completion on Ack, with a run-cycle count and a watchdog timeout flag. Sits between the host/bench Start/Ack interface and the CPU core's init and start-address inputs.

Parameters:
PC_W, 11, width of the program counter / start address.
CNT_W, 16, width of the run-cycle counter.
INIT_CYCLES, 2, cycles CoreInit is held after a start is accepted (≥1).
TIMEOUT_CYCLES, 16'hFFF0, run cycles before the watchdog fires (< 2^CNT_W).
NUM_PROG, 4, number of selectable programs. ProgSel width is clog2(NUM_PROG).

Ports:
Clk  in  1  clock; all state updates on posedge.
Reset  in  1  asynchronous, active-low reset; 0 resets the block.
Start  in  1  host request; the rising edge is the request.
ProgSel  in  2  program index; sampled only when a start is accepted.
CoreHalt  in  1  halt indication from the CPU core.
CoreInit  out  1  holds the core's PC/fetch in init while high.
StartAddr  out  PC_W  entry address for the core; valid while CoreInit is high.
Busy  out  1  high in the INIT and RUN states.
Ack  out  1  run complete; high in the DONE state.
CycleCount  out  CNT_W  RUN cycles in the current or last run.
Timeout  out  1  last run ended by the watchdog.

Behaviour:
- States: IDLE, INIT, RUN, DONE.
- Reset (Reset=0, asynchronous) forces:
  - state=IDLE, CoreInit=1, StartAddr=PROG_ADDR[0], Busy=0, Ack=0, CycleCount=0, Timeout=0.
  - start_q=1, so a Start held high through reset is not taken as an edge.
  - init counter=0.
- Start detection: start_q registers Start every cycle. A request is Start=1 while start_q=0.
- IDLE or DONE, request:
  - ProgSel is latched; StartAddr becomes PROG_ADDR[ProgSel].
  - CycleCount=0, Timeout=0, Ack=0, init counter=0.
  - Next state is INIT.
- IDLE or DONE, no request: hold all outputs.
- An out-of-range ProgSel (≥NUM_PROG) maps to PROG_ADDR[0].
- INIT:
  - CoreInit=1, Busy=1.
  - The init counter increments each cycle.
  - After exactly INIT_CYCLES cycles in INIT, go to RUN. CoreInit drops to 0 on that edge.
- RUN:
  - CoreInit=0, Busy=1.
  - On each posedge, CycleCount increments, saturating at all-ones.
  - CoreHalt=1 sampled: go to DONE; Ack=1, Busy=0, Timeout=0. The count includes this cycle, so a halt in the first RUN cycle gives CycleCount=1.
  - CycleCount reaching TIMEOUT_CYCLES with CoreHalt=0: go to DONE with Timeout=1.
  - CoreHalt and timeout on the same edge: the halt wins, Timeout=0.
- DONE:
  - Ack=1; CoreInit returns to 1 so the core stays parked; Busy=0.
  - CycleCount and Timeout are frozen until the next request.
- Start edges in INIT or RUN are ignored; they are not queued.
- CoreHalt outside RUN is ignored. A stale halt from the previous run cannot end INIT.
- Latency: request sampled at edge N gives Busy=1 after N. RUN begins after edge N+INIT_CYCLES. Ack rises after the edge that samples the halt.
- Reset asserted mid-run aborts immediately to the reset values. No Ack is produced for the aborted run.

Decomposition:
- Shared package seq_pkg holds:
  - the state enum (IDLE, INIT, RUN, DONE);
  - the PROG_ADDR constant array: 0, 256, 512, 768;
  - the default widths.
- One natural sub-module: seq_watchdog. It is a saturating CNT_W counter with clear and enable inputs and a terminal-count output compared against TIMEOUT_CYCLES.
- The FSM and the start edge detection stay in the top.

Test Plan:
- Reset=0 with Start=1, then release Reset → no run starts; CoreInit=1, Ack=0, Busy=0 until Start falls and rises again.
- ProgSel=2, Start edge; core model halts on its 5th RUN cycle → StartAddr=512 during INIT; CoreInit high for 2 cycles; then Ack=1, CycleCount=5, Timeout=0.
- Back-to-back runs: ProgSel=1, then ProgSel=3 after Ack → second run shows StartAddr=768. Ack clears on the new request and CycleCount restarts from 0.
- CoreHalt held high through INIT, then in the first RUN cycle → halt ignored during INIT; DONE with CycleCount=1.
- TIMEOUT_CYCLES=20, core never halts → DONE with Timeout=1, CycleCount=20. Repeat with CoreHalt=1 in cycle 20 → Timeout=0.
- Start edge during RUN, then Reset=0 asserted mid-RUN → the extra Start is ignored; reset returns to IDLE asynchronously with every output at its reset value and no Ack pulse.
